// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_arb_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } arb_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int pend_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: pipeline write, long-latency result, rf write, hazard queries.
// Latency: n/a (wires only).
// Backpressure: lu_ready towards the unit, wb_stall towards the pipeline.
interface wb_port_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = pend_cnt_w(DEPTH);

  logic            pipe_we;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            lu_valid;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            lu_ready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            wb_stall;
  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic [4:0]      q_rd;
  logic            pend_hit1;
  logic            pend_hit2;
  logic            pend_hitd;
  logic [CW-1:0]   pend_cnt;

  // Environment side: pipeline, long-latency unit and hazard unit.
  modport master (
    output pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data, q_rs1, q_rs2, q_rd,
    input  lu_ready, rf_we, rf_rd, rf_wdata, wb_stall, pend_hit1, pend_hit2, pend_hitd, pend_cnt
  );

  // Arbiter side.
  modport slave (
    input  pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data, q_rs1, q_rs2, q_rd,
    output lu_ready, rf_we, rf_rd, rf_wdata, wb_stall, pend_hit1, pend_hit2, pend_hitd, pend_cnt
  );

endinterface

// File: rtl/wb_pend_fifo.sv
// Circular buffer of pending {rd, data} results with three parallel rd lookups.
// Latency: push visible at head/lookups the cycle after the edge; head and lookups are combinational.
// Backpressure: full blocks push (caller must check); pop on empty is ignored.
module wb_pend_fifo
  import wb_arb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int CW   = pend_cnt_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [4:0]      push_rd,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  output logic [4:0]      head_rd,
  output logic [XLEN-1:0] head_data,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   cnt,
  input  logic [4:0]      q_a,
  input  logic [4:0]      q_b,
  input  logic [4:0]      q_c,
  output logic            hit_a,
  output logic            hit_b,
  output logic            hit_c
);
  localparam int PW = $clog2(DEPTH);

  logic [4:0]      rd_q   [DEPTH];
  logic [4:0]      rd_d   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;
  logic [DEPTH-1:0] valid, m_a, m_b, m_c;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign cnt       = cnt_q;
  assign head_rd   = rd_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Next storage, pointers and occupancy from push/pop.
  always_comb begin
    rd_d     = rd_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      rd_d[wr_ptr_q]   = push_rd;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Buffer state; reset drops every pending entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_q     <= rd_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry valid when its distance from the head is below occupancy; compare rd per query.
  always_comb begin
    logic [PW-1:0] off;
    off   = '0;
    valid = '0;
    m_a   = '0;
    m_b   = '0;
    m_c   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - rd_ptr_q;
      valid[i] = ({1'b0, off} < cnt_q);
      m_a[i]   = (rd_q[i] == q_a);
      m_b[i]   = (rd_q[i] == q_b);
      m_c[i]   = (rd_q[i] == q_c);
    end
  end

  assign hit_a = (q_a != REG_X0) && |(valid & m_a);
  assign hit_b = (q_b != REG_X0) && |(valid & m_b);
  assign hit_c = (q_c != REG_X0) && |(valid & m_c);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the rf write port between the pipeline and a queued long-latency unit.
// Latency: write-port select is combinational; queued results drain in FIFO order into free slots.
// Backpressure: lu_ready drops when the buffer is full; wb_stall forces a one-cycle drain after MAX_STARVE blocked cycles.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int MAX_STARVE = 8
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);
  localparam int CW = pend_cnt_w(DEPTH);
  localparam int SW = $clog2(MAX_STARVE) + 1;

  arb_state_e      state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic            pipe_slot, lu_ready, accept, lu_keep;
  logic            rf_we, bypass, push, pop, blocked;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;
  logic            full, empty;
  logic [CW-1:0]   cnt;

  assign pipe_slot = bus.pipe_we && (bus.pipe_rd != REG_X0);
  // Gated by reset so the unit never sees a handshake while the arbiter is held.
  assign lu_ready  = rst && !full;
  assign accept    = bus.lu_valid && lu_ready;
  // Results aimed at x0 are accepted and dropped.
  assign lu_keep   = accept && (bus.lu_rd != REG_X0);
  assign blocked   = (state_q == NORMAL) && !empty && pipe_slot;

  wb_pend_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_pend (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (bus.lu_rd),
    .push_data (bus.lu_data),
    .pop       (pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .cnt       (cnt),
    .q_a       (bus.q_rs1),
    .q_b       (bus.q_rs2),
    .q_c       (bus.q_rd),
    .hit_a     (bus.pend_hit1),
    .hit_b     (bus.pend_hit2),
    .hit_c     (bus.pend_hitd)
  );

  // Write-port owner: forced drain, then pipeline, then buffer head, then bypass.
  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = REG_X0;
    rf_wdata = '0;
    pop      = 1'b0;
    bypass   = 1'b0;
    if (!rst) begin
      rf_we = 1'b0;
    end else if (state_q == STALL) begin
      rf_we    = !empty;
      rf_rd    = head_rd;
      rf_wdata = head_data;
      pop      = 1'b1;
    end else if (pipe_slot) begin
      rf_we    = 1'b1;
      rf_rd    = bus.pipe_rd;
      rf_wdata = bus.pipe_data;
    end else if (!empty) begin
      rf_we    = 1'b1;
      rf_rd    = head_rd;
      rf_wdata = head_data;
      pop      = 1'b1;
    end else if (lu_keep) begin
      rf_we    = 1'b1;
      rf_rd    = bus.lu_rd;
      rf_wdata = bus.lu_data;
      bypass   = 1'b1;
    end
    push = lu_keep && !bypass;
  end

  // Starvation counter and NORMAL/STALL transitions.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (state_q == STALL) begin
      state_d  = NORMAL;
      starve_d = '0;
    end else if (blocked) begin
      if (starve_q == SW'(MAX_STARVE - 1)) begin
        state_d  = STALL;
        starve_d = '0;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end else begin
      starve_d = '0;
    end
  end

  // FSM and starvation registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign bus.lu_ready = lu_ready;
  assign bus.rf_we    = rf_we;
  assign bus.rf_rd    = rf_rd;
  assign bus.rf_wdata = rf_wdata;
  assign bus.wb_stall = (state_q == STALL);
  assign bus.pend_cnt = cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle, plus literal checkpoints.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later.
// Backpressure: pipeline inputs are held for the cycle after any wb_stall cycle.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int XLEN       = 32;
  localparam int DEPTH      = 4;
  localparam int MAX_STARVE = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(
    .XLEN       (XLEN),
    .DEPTH      (DEPTH),
    .MAX_STARVE (MAX_STARVE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model state.
  ent_t        mq[$];
  bit          m_stall;
  int          m_starve;

  // Per-cycle model decisions.
  bit          e_we, e_pop, e_push, e_slot, e_ready;
  logic [4:0]  e_rd, e_lrd;
  logic [31:0] e_data, e_ldata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic bit mhit(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stall  = 1'b0;
    m_starve = 0;
  endtask

  task automatic drive(input bit pwe, input logic [4:0] prd, input logic [31:0] pd,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    bus.pipe_we   = pwe;
    bus.pipe_rd   = prd;
    bus.pipe_data = pd;
    bus.lu_valid  = lv;
    bus.lu_rd     = lrd;
    bus.lu_data   = ld;
    bus.q_rs1     = a;
    bus.q_rs2     = b;
    bus.q_rd      = c;
  endtask

  // Derive what the outputs must be from the model and compare every output.
  task automatic model_check();
    bit acc, byp;
    e_slot  = bus.pipe_we && (bus.pipe_rd != 5'd0);
    e_ready = (mq.size() < DEPTH);
    acc     = bus.lu_valid && e_ready;
    e_lrd   = bus.lu_rd;
    e_ldata = bus.lu_data;
    e_we = 0; e_rd = 0; e_data = 0; e_pop = 0; e_push = 0; byp = 0;
    if (m_stall && mq.size() > 0) begin
      e_we = 1; e_rd = mq[0].rd; e_data = mq[0].data; e_pop = 1;
    end else if (!m_stall && e_slot) begin
      e_we = 1; e_rd = bus.pipe_rd; e_data = bus.pipe_data;
    end else if (!m_stall && mq.size() > 0) begin
      e_we = 1; e_rd = mq[0].rd; e_data = mq[0].data; e_pop = 1;
    end else if (!m_stall && acc && bus.lu_rd != 5'd0) begin
      e_we = 1; e_rd = bus.lu_rd; e_data = bus.lu_data; byp = 1;
    end
    e_push = acc && (bus.lu_rd != 5'd0) && !byp;
    chk("lu_ready", bus.lu_ready, e_ready);
    chk("wb_stall", bus.wb_stall, m_stall);
    chk("rf_we", bus.rf_we, e_we);
    if (e_we) begin
      chk("rf_rd", bus.rf_rd, e_rd);
      chk("rf_wdata", bus.rf_wdata, e_data);
    end
    chk("pend_cnt", bus.pend_cnt, mq.size());
    chk("pend_hit1", bus.pend_hit1, mhit(bus.q_rs1));
    chk("pend_hit2", bus.pend_hit2, mhit(bus.q_rs2));
    chk("pend_hitd", bus.pend_hitd, mhit(bus.q_rd));
  endtask

  task automatic step(input bit pwe, input logic [4:0] prd, input logic [31:0] pd,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    drive(pwe, prd, pd, lv, lrd, ld, a, b, c);
    #1;
    model_check();
  endtask

  // Advance the model across the rising edge, return at the next falling edge.
  task automatic tick();
    ent_t e;
    @(posedge clk);
    if (m_stall) begin
      m_stall  = 1'b0;
      m_starve = 0;
    end else if (mq.size() > 0 && e_slot) begin
      if (m_starve == MAX_STARVE - 1) begin
        m_stall  = 1'b1;
        m_starve = 0;
      end else begin
        m_starve++;
      end
    end else begin
      m_starve = 0;
    end
    if (e_pop) void'(mq.pop_front());
    if (e_push) begin
      e.rd   = e_lrd;
      e.data = e_ldata;
      mq.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          hold_pipe;
    bit          p_we;
    logic [4:0]  p_rd;
    logic [31:0] p_data;
    int          stall_k[$];

    model_reset();

    // Held in reset: everything quiet even with requests present.
    drive(1, 5'd3, 32'h1111, 1, 5'd5, 32'h2222, 5'd5, 5'd3, 5'd0);
    #3;
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_lu_ready", bus.lu_ready, 0);
    chk("rst_wb_stall", bus.wb_stall, 0);
    chk("rst_pend_cnt", bus.pend_cnt, 0);
    chk("rst_pend_hit1", bus.pend_hit1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Idle pipeline: long-latency result bypasses straight to the port.
    step(0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 0, 0);
    chk("byp_we", bus.rf_we, 1);
    chk("byp_rd", bus.rf_rd, 5);
    chk("byp_data", bus.rf_wdata, 32'hDEAD_BEEF);
    tick();
    step(0, 0, 0, 0, 0, 0, 5'd5, 0, 0);
    chk("byp_cnt", bus.pend_cnt, 0);
    chk("byp_nohit", bus.pend_hit1, 0);
    tick();

    // rd=0 result: accepted, dropped.  pipe rd=0: treated as a free slot.
    step(0, 0, 0, 1, 5'd0, 32'h1234, 0, 0, 0);
    chk("x0_ready", bus.lu_ready, 1);
    chk("x0_we", bus.rf_we, 0);
    tick();
    step(1, 5'd0, 32'hAAAA, 1, 5'd6, 32'h66, 0, 0, 0);
    chk("pipe_x0_byp_we", bus.rf_we, 1);
    chk("pipe_x0_byp_rd", bus.rf_rd, 6);
    chk("pipe_x0_byp_data", bus.rf_wdata, 32'h66);
    tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_cnt", bus.pend_cnt, 0);
    tick();

    // Bubble with {1,2} queued and a new result rd=9: pop head, push tail.
    step(1, 5'd20, 32'h20, 1, 5'd1, 32'h101, 0, 0, 0);
    tick();
    step(1, 5'd21, 32'h21, 1, 5'd2, 32'h102, 0, 0, 0);
    tick();
    step(0, 0, 0, 1, 5'd9, 32'h109, 5'd9, 5'd1, 5'd2);
    chk("bub_rd", bus.rf_rd, 1);
    chk("bub_data", bus.rf_wdata, 32'h101);
    chk("bub_cnt", bus.pend_cnt, 2);
    chk("bub_hit_notyet", bus.pend_hit1, 0);
    chk("bub_hit_popping", bus.pend_hit2, 1);
    tick();
    step(0, 0, 0, 0, 0, 0, 5'd1, 5'd9, 0);
    chk("drain1_rd", bus.rf_rd, 2);
    chk("drain1_cnt", bus.pend_cnt, 2);
    chk("drain1_hit9", bus.pend_hit2, 1);
    tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("drain2_rd", bus.rf_rd, 9);
    chk("drain2_data", bus.rf_wdata, 32'h109);
    tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("drain_empty_we", bus.rf_we, 0);
    chk("drain_empty_cnt", bus.pend_cnt, 0);
    tick();

    // Pipeline busy every cycle: fill, starve, forced drains, then async reset in STALL.
    hold_pipe = 0;
    p_rd = 0;
    p_data = 0;
    for (int k = 0; k <= 18; k++) begin
      if (!hold_pipe) begin
        p_rd   = 5'(10 + k);
        p_data = 32'hC000 + k;
      end
      step(1, p_rd, p_data, (k < 4), 5'(k + 1), 32'hB000 + k,
           (k == 5) ? 5'd7 : 5'd3, 5'd0, 5'd7);
      if (bus.wb_stall) stall_k.push_back(k);
      if (k == 4) begin
        chk("full_ready", bus.lu_ready, 0);
        chk("full_cnt", bus.pend_cnt, 4);
        chk("full_hit3", bus.pend_hit1, 1);
        chk("full_hit0", bus.pend_hit2, 0);
        chk("full_hit7", bus.pend_hitd, 0);
      end
      if (k == 5) chk("full_hit7_rs1", bus.pend_hit1, 0);
      if (k == 9) begin
        chk("stall1", bus.wb_stall, 1);
        chk("stall1_rd", bus.rf_rd, 1);
      end
      if (k == 10) begin
        chk("held_stall", bus.wb_stall, 0);
        chk("held_rd", bus.rf_rd, 19);
        chk("held_data", bus.rf_wdata, 32'hC009);
      end
      if (k == 18) begin
        chk("stall2_rd", bus.rf_rd, 2);
        chk("stall2_cnt", bus.pend_cnt, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("amid_wb_stall", bus.wb_stall, 0);
        chk("amid_rf_we", bus.rf_we, 0);
        chk("amid_cnt", bus.pend_cnt, 0);
        chk("amid_ready", bus.lu_ready, 0);
        chk("amid_hit", bus.pend_hit1, 0);
      end else begin
        hold_pipe = m_stall;
        tick();
      end
    end
    chk("stall_count", stall_k.size(), 2);
    if (stall_k.size() == 2) begin
      chk("stall_first_k", stall_k[0], 9);
      chk("stall_gap", stall_k[1] - stall_k[0], MAX_STARVE + 1);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Randomised traffic against the model.
    hold_pipe = 0;
    p_we = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold_pipe) begin
        p_we   = ($urandom_range(3) != 0);
        p_rd   = 5'($urandom_range(7));
        p_data = $urandom;
      end
      step(p_we, p_rd, p_data,
           ($urandom_range(2) == 0), 5'($urandom_range(7)), $urandom,
           5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
      hold_pipe = m_stall;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency execution unit (mul/div) that returns results out of band.
- Pipeline writes have priority. Unit results are queued in a small pending buffer and drained into free write slots.
- A starvation timer forces a one-cycle pipeline stall so that queued results always drain.
- Exposes pending-destination lookups so the hazard unit can stall RAW/WAW dependents on queued registers.

Parameters:
- XLEN, 32, data width
- DEPTH, 4, pending-buffer entries (power of two, ≥2)
- MAX_STARVE, 8, consecutive blocked cycles before a forced drain stall (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- pipe_we  in  1  writeback-stage write enable
- pipe_rd  in  5  writeback-stage destination register
- pipe_data  in  XLEN  writeback-stage result
- lu_valid  in  1  long-latency result valid
- lu_rd  in  5  long-latency destination register
- lu_data  in  XLEN  long-latency result
- lu_ready  out  1  arbiter accepts the long-latency result this cycle
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- wb_stall  out  1  pipeline must hold its writeback-stage inputs and freeze
- q_rs1, q_rs2, q_rd  in  5 each  hazard-unit query addresses
- pend_hit1, pend_hit2, pend_hitd  out  1 each  query matches a valid pending entry
- pend_cnt  out  clog2(DEPTH)+1  pending-buffer occupancy

Behaviour:
- **Reset (rst=0, async):**
  - Buffer empty, pend_cnt=0, state NORMAL, starve_cnt=0, wb_stall=0.
  - rf_we forced 0; pend_hit* = 0.
  - lu_ready = 1 combinationally once buffer is empty. It is gated to 0 while rst=0.
- **Definitions:**
  - pipe_slot = pipe_we && pipe_rd != 0.
  - lu_ready = !full.
  - Accept = lu_valid && lu_ready.
  - An accepted result with lu_rd == 0 is discarded and never stored or written.
- **Write-port selection (combinational, same cycle), in priority order:**
  1. state STALL: write buffer head, pop. pipe_* is ignored; the pipeline is holding it.
  2. NORMAL with pipe_slot: write pipe_rd/pipe_data.
  3. NORMAL, no pipe_slot, buffer non-empty: write head, pop.
  4. NORMAL, no pipe_slot, buffer empty, accept with lu_rd != 0: bypass lu_rd/lu_data directly, nothing stored.
  5. Otherwise rf_we = 0.
- **Push:** an accepted, nonzero-rd result not bypassed is written at the tail at the clock edge. Push and pop in the same cycle is legal; occupancy is unchanged. No push when full, even if popping.
- **Order:** the buffer is strict FIFO.
- **starve_cnt:**
  - Increments each NORMAL cycle with buffer non-empty and pipe_slot = 1.
  - Clears on any pop, when the buffer is empty, and on entering STALL.
- **FSM:**
  - NORMAL→STALL when starve_cnt == MAX_STARVE-1 and an increment condition holds. This is registered, so wb_stall=1 appears the next cycle.
  - STALL lasts exactly one cycle (one pop), then → NORMAL. wb_stall = (state == STALL).
- **Pipeline contract:** pipe_* is held stable while wb_stall=1. The held write is performed in the cycle after STALL.
- **Pending lookups:**
  - pend_hitX = 1 iff a valid entry's rd equals the query and the query != 0.
  - Combinational over stored entries. The entry being popped this cycle still counts.
  - The hazard unit uses pend_hitd to block WAW: a younger write to a pending rd must not reach writeback before the queued result.
- **Reset mid-operation:** pending entries are dropped; the long-latency unit is reset alongside.

Decomposition:
- Package wb_arb_pkg holds:
  - state enum {NORMAL, STALL}
  - REG_X0 = 5'd0
  - function computing the pend_cnt width
- One sub-module, wb_pend_fifo:
  - DEPTH-entry circular buffer of {rd, data}.
  - Push/pop, full/empty, count.
  - Three parallel rd-compare query ports.
- The top level holds port selection, bypass, starve_cnt and the FSM.

Test Plan:
- Idle pipeline, lu_valid with rd=5, data=0xDEAD_BEEF → rf_we=1, rf_rd=5 same cycle (bypass), pend_cnt stays 0.
- pipe_slot every cycle, 4 results pushed (rd=1..4) → lu_ready=0 at pend_cnt=4; pend_hit1=1 for q_rs1=3, 0 for q_rs1=0 and q_rs1=7.
- Continuous pipe_slot with non-empty buffer → wb_stall=1 exactly on cycle MAX_STARVE+1 after first block, head rd=1 written that cycle, held pipe write lands the next cycle, starve_cnt restarts.
- Pipeline bubble with buffer {rd=1,rd=2} and simultaneous lu_valid rd=9 → head rd=1 written, rd=9 pushed at tail, pend_cnt stays 2, later drain order 2 then 9.
- lu_valid with rd=0 → lu_ready=1, nothing stored or written; pipe_we=1 with pipe_rd=0 treated as a free slot.
- Assert rst low with 3 entries pending and FSM in STALL → wb_stall=0, rf_we=0, pend_cnt=0 immediately, without waiting for a clock edge.
